// File: rtl/wb_pkg.sv
// Shared Wishbone widths, arbiter state encoding and watchdog width.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package wb_pkg;

  localparam int ADR_W   = 36;
  localparam int DAT_W   = 32;
  localparam int SEL_W   = 4;

  // Watchdog counter width; TIMEOUT values up to 255 fit.
  localparam int CNT_W   = 8;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ENC_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ENC_OWNED = 2'd1;
  localparam logic [STATE_W-1:0] ENC_ABORT = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_OWNED = ENC_OWNED,
    ST_ABORT = ENC_ABORT
  } state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin pick: one-hot winner among requesters, searching from last+1 upward (mod NM).
// Latency: purely combinational.
// Backpressure: none; an all-zero request vector yields an all-zero pick.
module wb_rr_pick #(
  parameter int NM = 2,
  parameter int LW = 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [LW-1:0] last_i,
  output logic [NM-1:0] pick_o
);

  int rank [NM];
  int best;

  // Rank every master by its distance after the last owner; the nearest requester wins
  always_comb begin
    best = NM;
    for (int k = 0; k < NM; k++) begin
      rank[k] = (k + 2 * NM - 1 - int'(last_i)) % NM;
      if (req_i[k] && (rank[k] < best)) begin
        best = rank[k];
      end
    end
    for (int k = 0; k < NM; k++) begin
      pick_o[k] = req_i[k] && (rank[k] == best);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone N-master round-robin arbiter with bus lock and a stalled-strobe watchdog.
// Latency: one cycle IDLE->grant; request/ack paths are combinational while OWNED.
// Backpressure: slave stalls pass straight through; TIMEOUT stalled cycles abort with one err pulse.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NM*DAT_W-1:0] m_dat_i,
  input  logic [NM*ADR_W-1:0] m_adr_i,
  input  logic [NM-1:0]       m_we_i,
  input  logic [NM-1:0]       m_stb_i,
  input  logic [NM-1:0]       m_cyc_i,
  input  logic [NM*SEL_W-1:0] m_sel_i,
  output logic [DAT_W-1:0]    m_dat_o,
  output logic [NM-1:0]       m_ack_o,
  output logic [NM-1:0]       m_err_o,
  output logic [DAT_W-1:0]    s_dat_o,
  output logic [ADR_W-1:0]    s_adr_o,
  output logic [SEL_W-1:0]    s_sel_o,
  output logic                s_we_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [DAT_W-1:0]    s_dat_i,
  input  logic                s_ack_i,
  output logic [NM-1:0]       grant_o
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;

  state_e           state_q, state_d;
  logic [NM-1:0]    grant_q, grant_d;
  logic [NM-1:0]    err_q, err_d;
  logic [LW-1:0]    last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [NM-1:0]    pick;

  logic [LW-1:0]    owner_idx;
  logic             own_cyc, own_stb, own_we;
  logic [DAT_W-1:0] own_dat;
  logic [ADR_W-1:0] own_adr;
  logic [SEL_W-1:0] own_sel;

  wb_rr_pick #(
    .NM (NM),
    .LW (LW)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .pick_o (pick)
  );

  // Select the granted master's request lines and remember its index
  always_comb begin
    owner_idx = '0;
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_dat   = '0;
    own_adr   = '0;
    own_sel   = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) begin
        owner_idx = LW'(k);
        own_cyc   = m_cyc_i[k];
        own_stb   = m_stb_i[k];
        own_we    = m_we_i[k];
        own_dat   = m_dat_i[k*DAT_W +: DAT_W];
        own_adr   = m_adr_i[k*ADR_W +: ADR_W];
        own_sel   = m_sel_i[k*SEL_W +: SEL_W];
      end
    end
  end

  // Slave-side request and master acks are only live while a master owns the bus
  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    m_ack_o = '0;
    if (state_q == ST_OWNED) begin
      s_dat_o = own_dat;
      s_adr_o = own_adr;
      s_sel_o = own_sel;
      s_we_o  = own_we;
      s_stb_o = own_stb;
      s_cyc_o = own_cyc;
      // A reset cycle never completes a transfer
      if (s_ack_i && !rst) begin
        m_ack_o = grant_q;
      end
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign m_err_o = err_q;
  assign cnt_inc = cnt_q + 1'b1;

  // Next state: arbitrate in IDLE, hold the lock while cyc stays high, watchdog the strobe
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|m_cyc_i) begin
          grant_d = pick;
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_idx;
          grant_d = '0;
          cnt_d   = '0;
        end else if (own_stb && !s_ack_i) begin
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            // An ack in this same cycle would have taken the other branch
            err_d   = grant_q;
            state_d = ST_ABORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_ABORT: begin
        cnt_d = '0;
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_idx;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; master 0 wins the first arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      err_q   <= '0;
      last_q  <= LW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized masters.
// Latency: a reference model predicts every cycle's outputs; a monitor compares them.
// Backpressure: slave ack is randomized so stalls and watchdog aborts occur.
module tb_wb_rr_arbiter;

  localparam int NM      = 3;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*32-1:0]  m_dat_i;
  logic [NM*36-1:0]  m_adr_i;
  logic [NM-1:0]     m_we_i, m_stb_i, m_cyc_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic [31:0]       s_dat_o;
  logic [35:0]       s_adr_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o, s_stb_o, s_cyc_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i;

  wb_rr_arbiter #(.NM(NM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_we_i(m_we_i), .m_stb_i(m_stb_i),
    .m_cyc_i(m_cyc_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NM-1:0] grant;
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [35:0]   adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic [31:0]   mdat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Reference model state: who owns the bus, who owned it last, stall run length
  int md_owner = -1;
  int md_last  = NM - 1;
  int md_stall = 0;
  int md_err   = -1;
  bit md_abort = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc_n, act, want);
    end
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the model one clock
  task automatic model_step();
    exp_t e;
    int   c;
    e = '0;
    e.mdat = s_dat_i;
    if (md_owner >= 0) e.grant[md_owner] = 1'b1;
    if (md_err >= 0)   e.err[md_err] = 1'b1;
    if (md_owner >= 0 && !md_abort) begin
      e.cyc = m_cyc_i[md_owner];
      e.stb = m_stb_i[md_owner];
      e.we  = m_we_i[md_owner];
      e.adr = m_adr_i[md_owner*36 +: 36];
      e.dat = m_dat_i[md_owner*32 +: 32];
      e.sel = m_sel_i[md_owner*4 +: 4];
      if (s_ack_i && !rst) e.ack[md_owner] = 1'b1;
    end
    exp_q.push_back(e);

    if (rst) begin
      md_owner = -1; md_last = NM - 1; md_stall = 0; md_err = -1; md_abort = 1'b0;
    end else begin
      md_err = -1;
      if (md_owner < 0) begin
        for (int i = 1; i <= NM; i++) begin
          c = (md_last + i) % NM;
          if (md_owner < 0 && m_cyc_i[c]) md_owner = c;
        end
        md_stall = 0;
        md_abort = 1'b0;
      end else if (!m_cyc_i[md_owner]) begin
        md_last  = md_owner;
        md_owner = -1;
        md_stall = 0;
        md_abort = 1'b0;
      end else if (!md_abort) begin
        if (m_stb_i[md_owner] && !s_ack_i) begin
          md_stall++;
          if (md_stall == TIMEOUT) begin
            md_err   = md_owner;
            md_abort = 1'b1;
            md_stall = 0;
          end
        end else begin
          md_stall = 0;
        end
      end
    end
  endtask

  // Inputs for a cycle are settled at posedge+2; the model sees them, then the clock runs
  task automatic cycle();
    model_step();
    @(posedge clk);
    #2;
    cyc_n++;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [35:0] adr, input logic [31:0] dat);
    m_cyc_i[k]           = cyc;
    m_stb_i[k]           = stb;
    m_we_i[k]            = we;
    m_adr_i[k*36 +: 36]  = adr;
    m_dat_i[k*32 +: 32]  = dat;
    m_sel_i[k*4 +: 4]    = 4'hF;
  endtask

  task automatic new_data(input int k);
    logic [3:0] hi;
    hi = 4'($urandom_range(15, 0));
    m_adr_i[k*36 +: 36] = {hi, $urandom()};
    m_dat_i[k*32 +: 32] = $urandom();
    m_sel_i[k*4 +: 4]   = 4'($urandom_range(15, 0));
    m_we_i[k]           = 1'($urandom_range(1, 0));
  endtask

  // Monitor: every cycle that has a prediction, compare all DUT outputs against it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_o", 64'(grant_o), 64'(e.grant));
        chk("m_ack_o", 64'(m_ack_o), 64'(e.ack));
        chk("m_err_o", 64'(m_err_o), 64'(e.err));
        chk("s_cyc_o", 64'(s_cyc_o), 64'(e.cyc));
        chk("s_stb_o", 64'(s_stb_o), 64'(e.stb));
        chk("s_we_o",  64'(s_we_o),  64'(e.we));
        chk("s_adr_o", 64'(s_adr_o), 64'(e.adr));
        chk("s_dat_o", 64'(s_dat_o), 64'(e.dat));
        chk("s_sel_o", 64'(s_sel_o), 64'(e.sel));
        chk("m_dat_o", 64'(m_dat_o), 64'(e.mdat));
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_dat_i = '0; m_adr_i = '0; m_we_i = '0; m_stb_i = '0; m_cyc_i = '0; m_sel_i = '0;
    s_dat_i = 32'h1234_5678; s_ack_i = 1'b0;
    @(posedge clk);
    #2;

    // Reset state
    #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_err",   64'(m_err_o), 64'd0);
    chk("rst_scyc",  64'(s_cyc_o), 64'd0);
    cycle();
    rst = 1'b0;

    // Single write from m0, slave acks on the first owned cycle
    set_m(0, 1'b1, 1'b1, 1'b1, 36'h1, 32'hDEADBEEF);
    cycle();
    s_ack_i = 1'b1;
    #1;
    chk("w0_grant", 64'(grant_o), 64'b001);
    chk("w0_sdat",  64'(s_dat_o), 64'hDEADBEEF);
    chk("w0_sadr",  64'(s_adr_o), 64'h1);
    chk("w0_ack",   64'(m_ack_o), 64'b001);
    cycle();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    #1;
    chk("w0_ack_once", 64'(m_ack_o), 64'd0);
    cycle();
    #1;
    chk("w0_idle", 64'(grant_o), 64'd0);
    cycle();

    // Fresh reset, then m0 and m1 request together
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 36'h10, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 36'h20, 32'h0);
    cycle();
    #1;
    chk("pair_first", 64'(grant_o), 64'b001);
    cycle();
    set_m(0, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    #1;
    chk("pair_gap", 64'(grant_o), 64'd0);
    cycle();
    #1;
    chk("pair_second", 64'(grant_o), 64'b010);
    set_m(1, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    cycle();
    set_m(0, 1'b1, 1'b1, 1'b0, 36'h30, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 36'h40, 32'h0);
    cycle();
    #1;
    chk("pair_again", 64'(grant_o), 64'b001);
    set_m(0, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    cycle();

    // m1 holds a locked burst of 3 beats while m0 waits
    set_m(1, 1'b1, 1'b1, 1'b1, 36'h50, 32'hA5A5_0001);
    cycle();
    set_m(0, 1'b1, 1'b1, 1'b0, 36'h60, 32'h0);
    for (int b = 0; b < 3; b++) begin
      s_ack_i = 1'b1;
      #1;
      chk("lock_grant", 64'(grant_o), 64'b010);
      chk("lock_ack",   64'(m_ack_o), 64'b010);
      cycle();
    end
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    #1;
    chk("lock_release", 64'(grant_o), 64'd0);
    cycle();
    #1;
    chk("lock_next", 64'(grant_o), 64'b001);
    set_m(0, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    cycle();

    // Watchdog: slave never acks
    set_m(0, 1'b1, 1'b1, 1'b0, 36'h70, 32'h0);
    cycle();
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      chk("wd_no_err", 64'(m_err_o), 64'd0);
      cycle();
    end
    #1;
    chk("wd_err",     64'(m_err_o), 64'b001);
    chk("wd_scyc",    64'(s_cyc_o), 64'd0);
    cycle();
    #1;
    chk("wd_err_once", 64'(m_err_o), 64'd0);
    chk("wd_hold",     64'(grant_o), 64'b001);
    set_m(0, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    #1;
    chk("wd_idle", 64'(grant_o), 64'd0);
    cycle();

    // Watchdog: ack arrives on the last allowed stalled cycle
    set_m(0, 1'b1, 1'b1, 1'b0, 36'h80, 32'h0);
    cycle();
    for (int i = 0; i < TIMEOUT - 1; i++) cycle();
    s_ack_i = 1'b1;
    #1;
    chk("wd_late_ack", 64'(m_ack_o), 64'b001);
    cycle();
    s_ack_i = 1'b0;
    #1;
    chk("wd_late_noerr", 64'(m_err_o), 64'd0);
    chk("wd_late_scyc",  64'(s_cyc_o), 64'd1);
    set_m(0, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    cycle();

    // Reset in the middle of an m1 transfer
    set_m(1, 1'b1, 1'b1, 1'b0, 36'h90, 32'h0);
    cycle();
    #1;
    chk("mid_owner", 64'(grant_o), 64'b010);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 36'hA0, 32'h0);
    #1;
    chk("mid_scyc",  64'(s_cyc_o), 64'd0);
    chk("mid_grant", 64'(grant_o), 64'd0);
    chk("mid_ack",   64'(m_ack_o), 64'd0);
    chk("mid_err",   64'(m_err_o), 64'd0);
    cycle();
    #1;
    chk("mid_after", 64'(grant_o), 64'b001);
    set_m(0, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 36'h0, 32'h0);
    cycle();
    cycle();

    // Randomized masters, slave and occasional reset
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NM; k++) begin
        if (!m_cyc_i[k]) begin
          if ($urandom_range(3, 0) == 0) begin
            m_cyc_i[k] = 1'b1;
            new_data(k);
          end
          m_stb_i[k] = m_cyc_i[k] & ($urandom_range(3, 0) != 0);
        end else if ($urandom_range(7, 0) == 0) begin
          m_cyc_i[k] = 1'b0;
          m_stb_i[k] = 1'b0;
        end else begin
          m_stb_i[k] = ($urandom_range(3, 0) != 0);
          if ($urandom_range(1, 0) == 0) new_data(k);
        end
      end
      s_ack_i = ($urandom_range(2, 0) == 0);
      s_dat_i = $urandom();
      rst     = ($urandom_range(199, 0) == 0);
      cycle();
    end

    rst = 1'b0;
    s_ack_i = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    cycle();
    cycle();
    @(negedge clk);
    #1;
    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
